// File: rtl/s4ga_pkg.sv
// Shared sizing for the s4ga bit-serial LUT fabric.
// Config word layout: K select fields (LSB first) followed by the truth table in the top bits.
package s4ga_pkg;

  localparam int N      = 16;
  localparam int K      = 4;
  localparam int SI_W   = 4;

  localparam int IDX_W  = $clog2(N);
  localparam int TT_W   = 2 ** K;
  localparam int CFG_W  = K * IDX_W + TT_W;
  localparam int BEATS  = CFG_W / SI_W;
  localparam int SR_W   = CFG_W - SI_W;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int OUT_W  = 8;

  localparam int SEL_LSB = 0;
  localparam int SEL_W   = K * IDX_W;
  localparam int TT_LSB  = CFG_W - TT_W;

endpackage

// File: rtl/s4ga_lut.sv
// Combinational K-input LUT: K N:1 selects pick bits of lut_q, which then index the truth table.
module s4ga_lut
  import s4ga_pkg::*;
(
  input  logic [N-1:0]     i_lut_q,
  input  logic [SEL_W-1:0] i_sel,
  input  logic [TT_W-1:0]  i_tt,
  output logic             o_q
);

  logic [K-1:0] w_idx;

  // select 0 lands in the LSB of the truth-table index
  always_comb begin
    w_idx = '0;
    for (int k = 0; k < K; k++) begin
      w_idx[k] = i_lut_q[i_sel[k*IDX_W +: IDX_W]];
    end
  end

  assign o_q = i_tt[w_idx];

endmodule

// File: rtl/s4ga.sv
// Bit-serial LUT fabric: one LUT word arrives every BEATS clocks and is evaluated on its last beat.
// Nothing is stored beyond the partial word and the LUT output flops, so the stream must repeat.
module s4ga
  import s4ga_pkg::*;
(
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic            w_clk;
  logic            w_rst;
  logic [SI_W-1:0] w_si;
  logic [1:0]      w_unused_pins;

  assign w_clk         = io_in[0];
  assign w_rst         = io_in[1];
  assign w_si          = io_in[2 +: SI_W];
  assign w_unused_pins = io_in[7:6];

  logic [BEAT_W-1:0] r_beat;
  logic [IDX_W-1:0]  r_cur;
  logic [SR_W-1:0]   r_sr;
  logic [N-1:0]      r_lut_q;

  logic [CFG_W-1:0]  w_cfg;
  logic              w_last;
  logic              w_lut_bit;

  assign w_cfg  = {w_si, r_sr};
  assign w_last = (r_beat == BEAT_W'(BEATS - 1));

  s4ga_lut u_lut (
    .i_lut_q (r_lut_q),
    .i_sel   (w_cfg[SEL_LSB +: SEL_W]),
    .i_tt    (w_cfg[TT_LSB +: TT_W]),
    .o_q     (w_lut_bit)
  );

  // lut_q is written in place, so later LUTs in the frame see this frame's values
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_beat  <= '0;
      r_cur   <= '0;
      r_sr    <= '0;
      r_lut_q <= '0;
    end else if (w_last) begin
      r_lut_q[r_cur] <= w_lut_bit;
      r_cur          <= r_cur + IDX_W'(1);
      r_beat         <= '0;
    end else begin
      r_sr[int'(r_beat) * SI_W +: SI_W] <= w_si;
      r_beat                            <= r_beat + BEAT_W'(1);
    end
  end

  assign io_out = r_lut_q[OUT_W-1:0];

endmodule

// File: tb/tb_s4ga.sv
// Self-checking bench for s4ga: directed scenarios plus a randomized stream against a word-level model.
module tb_s4ga;

  logic       r_clk = 1'b0;
  logic       r_rst = 1'b1;
  logic [3:0] r_si = 4'h0;
  logic [1:0] r_unused = 2'b00;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {r_unused, r_si, r_rst, r_clk};

  s4ga dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 r_clk = ~r_clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: LUT values, target LUT, nibbles collected so far
  logic [15:0]  m_q = 16'h0000;
  int           m_cur = 0;
  int unsigned  m_nib[$];

  task automatic model_edge(input logic [3:0] si, input logic rst);
    logic [31:0] cfg;
    int idx;
    int sel;
    if (rst) begin
      m_q = 16'h0000;
      m_cur = 0;
      m_nib.delete();
    end else begin
      m_nib.push_back(int'(si));
      if (m_nib.size() == 8) begin
        cfg = 32'h0;
        for (int i = 0; i < 8; i++) cfg = cfg | (32'(m_nib[i]) << (4 * i));
        idx = 0;
        for (int k = 0; k < 4; k++) begin
          sel = int'((cfg >> (4 * k)) & 32'hF);
          if (m_q[sel]) idx = idx + (1 << k);
        end
        m_q[m_cur] = ((cfg >> (16 + idx)) & 32'h1) != 0;
        m_cur = (m_cur + 1) % 16;
        m_nib.delete();
      end
    end
  endtask

  task automatic beat(input logic [3:0] si, input logic rst);
    @(negedge r_clk);
    r_si = si;
    r_rst = rst;
    r_unused = 2'($urandom);
    @(posedge r_clk);
    #1;
    model_edge(si, rst);
  endtask

  task automatic send_word(input logic [31:0] cfg);
    for (int i = 0; i < 8; i++) beat(cfg[4*i +: 4], 1'b0);
  endtask

  function automatic logic [31:0] zero_tt_word();
    return {16'h0000, 16'($urandom)};
  endfunction

  task automatic test_reset();
    beat(4'hF, 1'b1);
    beat(4'hF, 1'b1);
    n_vec++;
    if (io_out !== 8'h00) begin
      n_err++;
      $display("FAIL reset: io_out=%h expected %h", io_out, 8'h00);
    end
  endtask

  task automatic test_constant();
    beat(4'h0, 1'b1);
    send_word(32'hFFFF_0000);
    n_vec++;
    if (io_out !== 8'h01) begin
      n_err++;
      $display("FAIL constant_first_word: io_out=%h expected %h", io_out, 8'h01);
    end
    for (int l = 1; l < 16; l++) send_word(zero_tt_word());
    send_word(32'hFFFF_0000);
    n_vec++;
    if (io_out !== 8'h01 || io_out !== m_q[7:0]) begin
      n_err++;
      $display("FAIL constant_next_frame: io_out=%h expected %h", io_out, 8'h01);
    end
  endtask

  task automatic test_toggle();
    logic [7:0] exp;
    beat(4'h0, 1'b1);
    for (int f = 0; f < 4; f++) begin
      send_word(32'h5555_0000);
      exp = (f % 2 == 0) ? 8'h01 : 8'h00;
      n_vec++;
      if (io_out !== exp) begin
        n_err++;
        $display("FAIL toggle_frame%0d: io_out=%h expected %h", f, io_out, exp);
      end
      for (int l = 1; l < 16; l++) send_word(zero_tt_word());
    end
  endtask

  task automatic test_chain();
    beat(4'h0, 1'b1);
    send_word(32'hFFFF_0000);
    send_word(32'hAAAA_0000);
    n_vec++;
    if (io_out !== 8'h03) begin
      n_err++;
      $display("FAIL chain: io_out=%h expected %h", io_out, 8'h03);
    end
  endtask

  task automatic test_order_wrap();
    logic [31:0] cfg;
    beat(4'h0, 1'b1);
    for (int f = 0; f < 2; f++) begin
      for (int l = 0; l < 16; l++) begin
        if (l == 0)      cfg = 32'hAAAA_8888;
        else if (l == 8) cfg = 32'hFFFF_0000;
        else             cfg = zero_tt_word();
        send_word(cfg);
        n_vec++;
        if (io_out[7:1] !== 7'h00) begin
          n_err++;
          $display("FAIL wrap_upper_f%0d_l%0d: io_out=%h expected upper bits 0", f, l, io_out);
        end
      end
      n_vec++;
      if (io_out[0] !== f[0]) begin
        n_err++;
        $display("FAIL wrap_bit0_frame%0d: io_out[0]=%b expected %b", f, io_out[0], f[0]);
      end
    end
  endtask

  task automatic test_mid_reset();
    beat(4'h0, 1'b1);
    send_word(32'hFFFF_0000);
    send_word(32'hAAAA_0000);
    n_vec++;
    if (io_out !== 8'h03) begin
      n_err++;
      $display("FAIL midrst_setup: io_out=%h expected %h", io_out, 8'h03);
    end
    for (int b = 0; b < 3; b++) beat(4'($urandom), 1'b0);
    beat(4'($urandom), 1'b1);
    n_vec++;
    if (io_out !== 8'h00) begin
      n_err++;
      $display("FAIL midrst_clear: io_out=%h expected %h", io_out, 8'h00);
    end
    send_word(32'hFFFF_0000);
    n_vec++;
    if (io_out !== 8'h01) begin
      n_err++;
      $display("FAIL midrst_lut0: io_out=%h expected %h", io_out, 8'h01);
    end
  endtask

  task automatic test_random();
    logic [3:0] si;
    logic       rst;
    beat(4'h0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      si  = 4'($urandom);
      rst = ($urandom_range(0, 399) == 0);
      beat(si, rst);
      n_vec++;
      if (io_out !== m_q[7:0]) begin
        n_err++;
        $display("FAIL random_beat%0d: io_out=%h expected %h", i, io_out, m_q[7:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_toggle();
    test_chain();
    test_order_wrap();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
